// File: rtl/usb_fs_pkg.sv
// Shared USB full-speed definitions: PID codes, TX arbiter state encoding and
// default bus timing constants.
package usb_fs_pkg;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_BUSY  = 2'd2,
        TX_GAP   = 2'd3
    } tx_arb_state_t;

    // Bus-idle bit times after EOP, and watchdog budget for a max FS packet plus stuffing.
    localparam int unsigned DEF_GAP_BITS     = 2;
    localparam int unsigned DEF_TIMEOUT_BITS = 1200;

endpackage

// File: rtl/usb_rr_pick.sv
// Round-robin priority encoder: returns the first asserted request at or after
// ptr, wrapping around the N inputs.
module usb_rr_pick #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    int unsigned cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) cand = cand - N;
            if (!any && req[cand[IW-1:0]]) begin
                any = 1'b1;
                idx = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/usb_fs_tx_arbiter.sv
// Shares one usb_fs_tx serializer between NUM_REQ packet sources: arbitration,
// pkt_start/pid issue, data routing, post-EOP idle gap and pkt_end watchdog.
module usb_fs_tx_arbiter
    import usb_fs_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned GAP_BITS     = DEF_GAP_BITS,
    parameter int unsigned TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
    input  logic                 clk_usb,
    input  logic                 reset,
    input  logic                 bit_strobe,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_pid,
    input  logic [NUM_REQ-1:0]   req_data_avail,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_data_get,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   req_done,
    output logic                 tx_pkt_start,
    output logic [3:0]           tx_pid,
    output logic                 tx_data_avail,
    output logic [7:0]           tx_data,
    input  logic                 tx_data_get,
    input  logic                 tx_pkt_end,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned RR_N  = NUM_REQ - 1;
    localparam int unsigned RR_W  = (RR_N > 1) ? $clog2(RR_N) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_BITS + 1);
    localparam int unsigned GAP_W = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

    tx_arb_state_t    state;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [WD_W-1:0]  wd;
    logic [GAP_W-1:0] gap;

    logic [3:0]       pid_arr  [NUM_REQ];
    logic [7:0]       data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
        assign pid_arr[i]  = req_pid[4*i +: 4];
        assign data_arr[i] = req_data[8*i +: 8];
    end

    // Requesters 1..NUM_REQ-1 share a round-robin; requester 0 overrides it.
    logic [RR_W-1:0]  rr_ptr_sub;
    logic [RR_W-1:0]  rr_idx;
    logic             rr_any;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] rr_next;

    assign rr_ptr_sub = RR_W'(rr_ptr - IDX_W'(1));

    usb_rr_pick #(.N(RR_N)) u_rr_pick (
        .req (req_valid[NUM_REQ-1:1]),
        .ptr (rr_ptr_sub),
        .idx (rr_idx),
        .any (rr_any)
    );

    assign win_idx = req_valid[0] ? '0 : IDX_W'(rr_idx) + IDX_W'(1);
    assign rr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : grant_idx + IDX_W'(1);

    always_ff @(posedge clk_usb) begin
        if (reset) begin
            state        <= TX_IDLE;
            grant_idx    <= '0;
            rr_ptr       <= IDX_W'(1);
            wd           <= '0;
            gap          <= '0;
            tx_pid       <= '0;
            tx_pkt_start <= 1'b0;
            req_ack      <= '0;
            req_done     <= '0;
            timeout_err  <= 1'b0;
        end else begin
            tx_pkt_start <= 1'b0;
            req_ack      <= '0;
            req_done     <= '0;
            timeout_err  <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (req_valid[0] || rr_any) begin
                        grant_idx    <= win_idx;
                        tx_pid       <= pid_arr[win_idx];
                        tx_pkt_start <= 1'b1;
                        req_ack      <= NUM_REQ'(1) << win_idx;
                        state        <= TX_START;
                    end
                end
                TX_START: begin
                    wd <= '0;
                    if (grant_idx != '0) rr_ptr <= rr_next;
                    state <= TX_BUSY;
                end
                // pkt_end takes precedence over a watchdog expiry in the same cycle.
                TX_BUSY: begin
                    if (tx_pkt_end) begin
                        req_done <= NUM_REQ'(1) << grant_idx;
                        gap      <= '0;
                        state    <= TX_GAP;
                    end else if (wd == WD_W'(TIMEOUT_BITS)) begin
                        timeout_err <= 1'b1;
                        req_done    <= NUM_REQ'(1) << grant_idx;
                        gap         <= '0;
                        state       <= TX_GAP;
                    end else if (bit_strobe) begin
                        wd <= wd + WD_W'(1);
                    end
                end
                TX_GAP: begin
                    if (gap == GAP_W'(GAP_BITS)) state <= TX_IDLE;
                    else if (bit_strobe) gap <= gap + GAP_W'(1);
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    // Data path follows the registered grant only while a packet owns the serializer.
    logic route_en;

    assign route_en      = (state == TX_START) || (state == TX_BUSY);
    assign busy          = (state != TX_IDLE);
    assign tx_data       = route_en ? data_arr[grant_idx] : '0;
    assign tx_data_avail = route_en ? req_data_avail[grant_idx] : 1'b0;
    assign req_data_get  = route_en ? (NUM_REQ'(tx_data_get) << grant_idx) : '0;

endmodule
